unified_mem_arbiter: RTL
========================

UNIFIED_MEM_ARBITER -- requirements
Module: unified_mem_arbiter

Interface
REQ-001 Parameter: ADDR_W, default 16, meaning: word address width.
REQ-002 Parameter: LINE_W, default 64, meaning: cache line width (4 x 16-bit words).
REQ-003 Parameter: STARVE_MAX, default 4, meaning: max consecutive D grants while I pending.
REQ-004 clk  in  1  the single clock; all state changes on posedge clk.
REQ-005 rst_n  in  1  reset, synchronous and active-low.
REQ-006 i_req  in  1  I-cache fill request; held high until i_done.
REQ-007 i_addr  in  ADDR_W  I-fill line address.
REQ-008 d_req  in  1  D-cache request (fill or writeback); held high until d_done.
REQ-009 d_we  in  1  1 = writeback, 0 = fill.
REQ-010 d_addr  in  ADDR_W  D line address.
REQ-011 d_wdata  in  LINE_W  writeback line.
REQ-012 i_done, d_done  out  1 each  one-cycle completion pulse per requester.
REQ-013 rdata  out  LINE_W  registered fill data, valid in done cycle.
REQ-014 u_re, u_we  out  1 each  unified memory read/write strobes.
REQ-015 u_addr  out  ADDR_W; u_wdata  out  LINE_W  latched memory address and data.
REQ-016 u_rdata  in  LINE_W; u_rdy  in  1  memory data and completion.

Function
REQ-017 States SHALL be IDLE, I_BUSY, D_BUSY.
REQ-018 In IDLE, a grant is decided combinationally from eligible requests and registered at the next edge into I_BUSY or D_BUSY.
REQ-019 On grant, u_addr and u_wdata SHALL latch the winner's address and data; they stay constant for the whole transaction.
REQ-020 u_re SHALL be high throughout I_BUSY, and throughout D_BUSY when the latched d_we = 0; u_we SHALL be high throughout D_BUSY when the latched d_we = 1; the two are never high together.
REQ-021 In a BUSY state with u_rdy = 1 at an edge, the arbiter SHALL return to IDLE and pulse the matching done for exactly one cycle, with rdata <= u_rdata for reads; minimum latency is req to done = 3 cycles.
REQ-022 A requester whose done is high SHALL be masked from arbitration that cycle, so stale requests are never re-granted.
REQ-023 Default policy: D wins over I; a 3-bit counter counts consecutive D grants while i_req is pending, and when it reaches STARVE_MAX, I SHALL win the next grant.
REQ-024 The counter SHALL clear on any I grant, or when i_req is low in IDLE.
REQ-025 Requests arriving during a BUSY state SHALL wait; they are not lost, because req is held.
REQ-026 The arbiter SHALL never assert done without a prior grant; u_rdy in IDLE is ignored.

Reset
REQ-027 While rst_n = 0 at an edge: state <= IDLE; all outputs <= 0; starve counter <= 0; round-robin pointer <= D-first.
REQ-028 Reset mid-transaction SHALL abort it with no done pulse; u_re and u_we drop at that edge.

Configuration
REQ-029 Macro ARB_RR_EN defined: when both requests are eligible in IDLE, the winner alternates using a last-winner pointer, and the starve counter is not built.
REQ-030 ARB_RR_EN undefined: fixed D priority with the starvation limit per REQ-023.

Structure
REQ-031 Shared package arb_pkg SHALL hold state encodings (IDLE = 2'b00, I_BUSY = 2'b01, D_BUSY = 2'b10), ADDR_W/LINE_W defaults and STARVE_MAX.
REQ-032 One sub-module, arb_pick, SHALL contain the combinational winner selection plus the starve counter or RR pointer.

Verification
REQ-033 i_req only, i_addr = 0x0040, u_rdy 2 cycles after u_re -> u_re with u_addr = 0x0040, one i_done pulse, rdata = u_rdata.
REQ-034 i_req and d_req (d_we = 1) in the same cycle -> D_BUSY first with u_we = 1 and u_wdata = d_wdata; then I_BUSY; i_done follows d_done.
REQ-035 i_req held while d_req is re-raised 5 times (ARB_RR_EN undefined) -> 4 D grants, then an I grant.
REQ-036 ARB_RR_EN defined, both requests held continuously -> grants alternate D, I, D, I.
REQ-037 rst_n low during D_BUSY before u_rdy -> next cycle IDLE, outputs 0, no d_done; u_rdy asserted afterwards is ignored.
REQ-038 Requester keeps req high during its done cycle -> no re-grant that cycle; a new grant only in a later cycle.

Source files
------------

// File: rtl/arb_pkg.sv
// Shared definitions for the unified I/D memory arbiter: FSM encodings and
// parameter defaults used by the interface, picker and top.
package arb_pkg;

    localparam int ADDR_W_DEF     = 16;
    localparam int LINE_W_DEF     = 64;
    localparam int STARVE_MAX_DEF = 4;
    localparam int CNT_W          = 3;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        I_BUSY = 2'b01,
        D_BUSY = 2'b10
    } arb_state_e;

endpackage

// File: rtl/unified_mem_arbiter_if.sv
// Bundle of requester-side and memory-side signals of the arbiter.
// Handshake: req is held high until its one-cycle done pulse; u_rdy completes a busy strobe.
interface unified_mem_arbiter_if #(
    parameter int ADDR_W = arb_pkg::ADDR_W_DEF,
    parameter int LINE_W = arb_pkg::LINE_W_DEF
) ();

    logic              i_req;
    logic [ADDR_W-1:0] i_addr;
    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [LINE_W-1:0] d_wdata;
    logic              i_done;
    logic              d_done;
    logic [LINE_W-1:0] rdata;
    logic              u_re;
    logic              u_we;
    logic [ADDR_W-1:0] u_addr;
    logic [LINE_W-1:0] u_wdata;
    logic [LINE_W-1:0] u_rdata;
    logic              u_rdy;

    modport slave (
        input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, u_rdata, u_rdy,
        output i_done, d_done, rdata, u_re, u_we, u_addr, u_wdata
    );

    modport master (
        output i_req, i_addr, d_req, d_we, d_addr, d_wdata, u_rdata, u_rdy,
        input  i_done, d_done, rdata, u_re, u_we, u_addr, u_wdata
    );

endinterface

// File: rtl/arb_pick.sv
// Winner selection for the arbiter. Default: D priority with a starvation limit for I.
// With ARB_RR_EN defined, a last-winner pointer alternates between contending requesters.
module arb_pick
    import arb_pkg::*;
#(
    parameter int STARVE_MAX = STARVE_MAX_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic arb_en_i,
    input  logic in_idle_i,
    input  logic i_elig_i,
    input  logic d_elig_i,
    output logic grant_i_o,
    output logic grant_d_o
);

    logic win_i;

`ifdef ARB_RR_EN
    logic prefer_d_q;

    assign win_i = i_elig_i & (~d_elig_i | ~prefer_d_q);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            prefer_d_q <= 1'b1;
        end else if (in_idle_i && grant_i_o) begin
            prefer_d_q <= 1'b1;
        end else if (in_idle_i && grant_d_o) begin
            prefer_d_q <= 1'b0;
        end
    end
`else
    logic [CNT_W-1:0] starve_q;
    logic             starved;

    assign starved = (starve_q >= CNT_W'(STARVE_MAX));
    assign win_i   = i_elig_i & (~d_elig_i | starved);

    // Saturating count of D grants taken while I was waiting.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            starve_q <= '0;
        end else if (grant_i_o) begin
            starve_q <= '0;
        end else if (in_idle_i && !i_elig_i) begin
            starve_q <= '0;
        end else if (grant_d_o && i_elig_i && !starved) begin
            starve_q <= starve_q + CNT_W'(1);
        end
    end
`endif

    assign grant_i_o = arb_en_i & win_i;
    assign grant_d_o = arb_en_i & d_elig_i & ~win_i;

endmodule

// File: rtl/unified_mem_arbiter.sv
// Arbitrates I-cache fills and D-cache fills/writebacks onto one unified memory port.
// Optional round-robin policy via macro ARB_RR_EN (see arb_pick).
module unified_mem_arbiter
    import arb_pkg::*;
#(
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int LINE_W     = LINE_W_DEF,
    parameter int STARVE_MAX = STARVE_MAX_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    unified_mem_arbiter_if.slave  bus,
    output logic [1:0]            state_o
);

    arb_state_e        state_q;
    logic              u_re_q;
    logic              u_we_q;
    logic [ADDR_W-1:0] u_addr_q;
    logic [LINE_W-1:0] u_wdata_q;
    logic [LINE_W-1:0] rdata_q;
    logic              i_done_q;
    logic              d_done_q;

    logic in_idle;
    logic arb_en;
    logic i_elig;
    logic d_elig;
    logic grant_i;
    logic grant_d;

    // A finished requester still shows its old req during the done cycle, so
    // arbitration pauses for that cycle and resumes once reqs are current.
    assign in_idle = (state_q == IDLE);
    assign i_elig  = bus.i_req & ~i_done_q;
    assign d_elig  = bus.d_req & ~d_done_q;
    assign arb_en  = in_idle & ~i_done_q & ~d_done_q;

    arb_pick #(
        .STARVE_MAX (STARVE_MAX)
    ) u_pick (
        .clk       (clk),
        .rst_n     (rst_n),
        .arb_en_i  (arb_en),
        .in_idle_i (in_idle),
        .i_elig_i  (i_elig),
        .d_elig_i  (d_elig),
        .grant_i_o (grant_i),
        .grant_d_o (grant_d)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            u_re_q    <= 1'b0;
            u_we_q    <= 1'b0;
            u_addr_q  <= '0;
            u_wdata_q <= '0;
            rdata_q   <= '0;
            i_done_q  <= 1'b0;
            d_done_q  <= 1'b0;
        end else begin
            i_done_q <= 1'b0;
            d_done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (grant_d) begin
                        state_q   <= D_BUSY;
                        u_addr_q  <= bus.d_addr;
                        u_wdata_q <= bus.d_wdata;
                        u_we_q    <= bus.d_we;
                        u_re_q    <= ~bus.d_we;
                    end else if (grant_i) begin
                        state_q   <= I_BUSY;
                        u_addr_q  <= bus.i_addr;
                        u_wdata_q <= '0;
                        u_we_q    <= 1'b0;
                        u_re_q    <= 1'b1;
                    end
                end
                I_BUSY: begin
                    if (bus.u_rdy) begin
                        state_q  <= IDLE;
                        u_re_q   <= 1'b0;
                        i_done_q <= 1'b1;
                        rdata_q  <= bus.u_rdata;
                    end
                end
                D_BUSY: begin
                    if (bus.u_rdy) begin
                        state_q  <= IDLE;
                        u_re_q   <= 1'b0;
                        u_we_q   <= 1'b0;
                        d_done_q <= 1'b1;
                        if (u_re_q) begin
                            rdata_q <= bus.u_rdata;
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                    u_re_q  <= 1'b0;
                    u_we_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.u_re    = u_re_q;
    assign bus.u_we    = u_we_q;
    assign bus.u_addr  = u_addr_q;
    assign bus.u_wdata = u_wdata_q;
    assign bus.rdata   = rdata_q;
    assign bus.i_done  = i_done_q;
    assign bus.d_done  = d_done_q;
    assign state_o     = state_q;

endmodule
